tt_fitness_sequencer: RTL and testbench

//  Sweeps all 2^N_IN input vectors into an evolved gate-level boolean circuit (DUT) and scores it.
//  For each vector: drive it, wait SETTLE_CYCLES for gate delays to propagate, then sample dut_out.

---
 rtl/tt_seq_pkg.sv | 34 +++
 rtl/tt_popcount.sv | 19 +
 rtl/tt_fitness_sequencer.sv | 172 +++++++++++++++++
 tb/tb_tt_fitness_sequencer.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tt_seq_pkg.sv
// Shared types and helpers for the truth-table fitness sequencer.
// Optional first-failure capture is enabled by defining TT_FAIL_CAPTURE_EN.
package tt_seq_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      SAMPLE = 2'd2,
      DONE   = 2'd3
   } tt_state_t;

   localparam int TT_N_IN   = 4;
   localparam int TT_N_OUT  = 4;
   localparam int TT_SETTLE = 8;

   // Upper bounds for the generic slice helper; larger tables need these raised.
   localparam int TT_TBL_MAX = 1024;
   localparam int TT_OUT_MAX = 32;

   function automatic int tt_fit_w(input int n_in, input int n_out);
      return $clog2(n_out * (1 << n_in) + 1);
   endfunction

   function automatic logic [TT_OUT_MAX-1:0] tt_slice(
      input logic [TT_TBL_MAX-1:0] tbl,
      input int                    n_out,
      input int                    v
   );
      logic [TT_TBL_MAX-1:0] s;
      s = tbl >> (v * n_out);
      return s[TT_OUT_MAX-1:0];
   endfunction

endpackage

// File: rtl/tt_popcount.sv
// Combinational count of ones across a W-bit vector.
// Used to score the per-vector match mask.
module tt_popcount #(
   parameter int W  = 4,
   parameter int CW = $clog2(W + 1)
) (
   input  logic [W-1:0]  bits,
   output logic [CW-1:0] ones
);

   // Sum every bit of the input.
   always_comb begin
      ones = '0;
      for (int i = 0; i < W; i++) begin
         ones = ones + CW'(bits[i]);
      end
   end

endmodule

// File: rtl/tt_fitness_sequencer.sv
// Sweeps every input vector through an evolved circuit and scores its truth table.
// Define TT_FAIL_CAPTURE_EN to build the first-mismatch capture registers.
module tt_fitness_sequencer
   import tt_seq_pkg::*;
#(
   parameter int N_IN          = TT_N_IN,
   parameter int N_OUT         = TT_N_OUT,
   parameter int SETTLE_CYCLES = TT_SETTLE,
   parameter int FIT_W         = tt_fit_w(N_IN, N_OUT)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic                         abort,
   input  logic [N_OUT*(2**N_IN)-1:0]   target_table,
   output logic [N_IN-1:0]              dut_in,
   input  logic [N_OUT-1:0]             dut_out,
   output logic                         busy,
   output logic                         done,
   output logic [FIT_W-1:0]             fitness,
   output logic                         perfect,
   output logic                         fail_valid,
   output logic [N_IN-1:0]              fail_vec,
   output logic [N_OUT-1:0]             fail_mask
);

   localparam int NVEC  = 1 << N_IN;
   localparam int TBL_W = N_OUT * NVEC;
   localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam int PCW   = $clog2(N_OUT + 1);

   localparam logic [N_IN:0]      LAST     = (N_IN + 1)'(NVEC - 1);
   localparam logic [CNT_W-1:0]   CNT_INIT = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [FIT_W-1:0]   MAXF     = FIT_W'(TBL_W);

   tt_state_t          state;
   logic [TBL_W-1:0]   tgt;
   logic [N_IN:0]      vec;
   logic [CNT_W-1:0]   cnt;
   logic [FIT_W-1:0]   acc;

   logic [N_OUT-1:0]   tv;
   logic [N_OUT-1:0]   match;
   logic [PCW-1:0]     pc;
   logic               launch;

   assign launch = (state == IDLE) && start && !abort;

   assign tv    = N_OUT'(tt_slice(TT_TBL_MAX'(tgt), N_OUT, int'(vec)));
   assign match = ~(dut_out ^ tv);

   tt_popcount #(
      .W  (N_OUT),
      .CW (PCW)
   ) u_pc (
      .bits (match),
      .ones (pc)
   );

   // Sweep FSM: settle, sample, advance, publish.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         tgt     <= '0;
         vec     <= '0;
         cnt     <= '0;
         acc     <= '0;
         dut_in  <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         fitness <= '0;
         perfect <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (launch) begin
                  tgt    <= target_table;
                  acc    <= '0;
                  vec    <= '0;
                  dut_in <= '0;
                  cnt    <= CNT_INIT;
                  busy   <= 1'b1;
                  state  <= SETTLE;
               end
            end
            SETTLE: begin
               if (abort) begin
                  vec    <= '0;
                  dut_in <= '0;
                  busy   <= 1'b0;
                  state  <= IDLE;
               end else if (cnt == '0) begin
                  state <= SAMPLE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            SAMPLE: begin
               if (abort) begin
                  vec    <= '0;
                  dut_in <= '0;
                  busy   <= 1'b0;
                  state  <= IDLE;
               end else begin
                  acc <= acc + FIT_W'(pc);
                  if (vec == LAST) begin
                     state <= DONE;
                  end else begin
                     vec    <= vec + 1'b1;
                     dut_in <= N_IN'(vec + 1'b1);
                     cnt    <= CNT_INIT;
                     state  <= SETTLE;
                  end
               end
            end
            DONE: begin
               fitness <= acc;
               perfect <= (acc == MAXF);
               done    <= 1'b1;
               busy    <= 1'b0;
               vec     <= '0;
               dut_in  <= '0;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef TT_FAIL_CAPTURE_EN
   logic [N_OUT-1:0] miss;
   logic             sh_valid;
   logic [N_IN-1:0]  sh_vec;
   logic [N_OUT-1:0] sh_mask;

   assign miss = dut_out ^ tv;

   // Hold the first mismatching vector, publish it alongside the score.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sh_valid   <= 1'b0;
         sh_vec     <= '0;
         sh_mask    <= '0;
         fail_valid <= 1'b0;
         fail_vec   <= '0;
         fail_mask  <= '0;
      end else begin
         if (launch) begin
            sh_valid <= 1'b0;
            sh_vec   <= '0;
            sh_mask  <= '0;
         end else if (state == SAMPLE && !abort &&
                      miss != '0 && !sh_valid) begin
            sh_valid <= 1'b1;
            sh_vec   <= vec[N_IN-1:0];
            sh_mask  <= miss;
         end
         if (state == DONE) begin
            fail_valid <= sh_valid;
            fail_vec   <= sh_vec;
            fail_mask  <= sh_mask;
         end
      end
   end
`else
   assign fail_valid = 1'b0;
   assign fail_vec   = '0;
   assign fail_mask  = '0;
`endif

endmodule

// File: tb/tb_tt_fitness_sequencer.sv
// Directed bench for tt_fitness_sequencer at default parameters.
// Feature checks follow TT_FAIL_CAPTURE_EN when defined.
module tb_tt_fitness_sequencer;

   logic        clk;
   logic        rst;
   logic        start;
   logic        abort;
   logic [63:0] target_table;
   logic [3:0]  dut_in;
   logic [3:0]  dut_out;
   logic        busy;
   logic        done;
   logic [6:0]  fitness;
   logic        perfect;
   logic        fail_valid;
   logic [3:0]  fail_vec;
   logic [3:0]  fail_mask;

   logic        loop;
   logic [3:0]  cst;

   int vectors;
   int miscompares;

   assign dut_out = loop ? dut_in : cst;

   tt_fitness_sequencer u_dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .abort        (abort),
      .target_table (target_table),
      .dut_in       (dut_in),
      .dut_out      (dut_out),
      .busy         (busy),
      .done         (done),
      .fitness      (fitness),
      .perfect      (perfect),
      .fail_valid   (fail_valid),
      .fail_vec     (fail_vec),
      .fail_mask    (fail_mask)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [63:0] ident_tbl();
      logic [63:0] t;
      for (int v = 0; v < 16; v++) t[v*4 +: 4] = 4'(v);
      return t;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(output int lat);
      lat = 0;
      for (int i = 0; i < 400; i++) begin
         tick();
         lat++;
         if (done) return;
      end
      vectors++;
      miscompares++;
      $display("FAIL done_timeout: no done within %0d cycles", lat);
      lat = -1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      start = 1'b0;
      abort = 1'b0;
      loop = 1'b1;
      cst = 4'h0;
      target_table = ident_tbl();
      repeat (3) tick();
      vectors++;
      if ({busy, done, perfect, fitness, dut_in, fail_valid, fail_vec, fail_mask}
          !== '0) begin
         miscompares++;
         $display("FAIL reset_outputs: busy=%b done=%b fit=%0d din=%h fv=%b",
                  busy, done, fitness, dut_in, fail_valid);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_loopback();
      int lat;
      loop = 1'b1;
      target_table = ident_tbl();
      pulse_start();
      vectors++;
      if (busy !== 1'b1) begin
         miscompares++;
         $display("FAIL lb_busy: got %b want 1", busy);
      end
      wait_done(lat);
      vectors++;
      if (lat != 145) begin
         miscompares++;
         $display("FAIL lb_latency: got %0d want 145", lat);
      end
      vectors++;
      if (fitness !== 7'd64 || perfect !== 1'b1) begin
         miscompares++;
         $display("FAIL lb_score: fit=%0d perf=%b want 64/1", fitness, perfect);
      end
      vectors++;
      if (fail_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL lb_fail_valid: got %b want 0", fail_valid);
      end
      tick();
      vectors++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL lb_after: done=%b busy=%b want 0/0", done, busy);
      end
   endtask

   task automatic test_const();
      int lat;
      loop = 1'b0;
      cst = 4'hF;
      target_table = '0;
      pulse_start();
      wait_done(lat);
      vectors++;
      if (fitness !== 7'd0 || perfect !== 1'b0) begin
         miscompares++;
         $display("FAIL const_score: fit=%0d perf=%b want 0/0", fitness, perfect);
      end
`ifdef TT_FAIL_CAPTURE_EN
      vectors++;
      if ({fail_valid, fail_vec, fail_mask} !== {1'b1, 4'h0, 4'hF}) begin
         miscompares++;
         $display("FAIL const_capture: fv=%b vec=%h mask=%h want 1/0/F",
                  fail_valid, fail_vec, fail_mask);
      end
`else
      vectors++;
      if ({fail_valid, fail_vec, fail_mask} !== '0) begin
         miscompares++;
         $display("FAIL const_tied: fv=%b vec=%h mask=%h want 0",
                  fail_valid, fail_vec, fail_mask);
      end
`endif
      loop = 1'b1;
   endtask

   task automatic run_flip();
      int lat;
      logic [63:0] t;
      t = ident_tbl();
      t[38] = ~t[38];
      loop = 1'b1;
      target_table = t;
      pulse_start();
      wait_done(lat);
   endtask

   task automatic test_flip();
      run_flip();
      vectors++;
      if (fitness !== 7'd63 || perfect !== 1'b0) begin
         miscompares++;
         $display("FAIL flip_score: fit=%0d perf=%b want 63/0", fitness, perfect);
      end
`ifdef TT_FAIL_CAPTURE_EN
      vectors++;
      if ({fail_valid, fail_vec, fail_mask} !== {1'b1, 4'h9, 4'b0100}) begin
         miscompares++;
         $display("FAIL flip_capture: fv=%b vec=%h mask=%b want 1/9/0100",
                  fail_valid, fail_vec, fail_mask);
      end
`endif
   endtask

   task automatic test_abort();
      int dn;
      run_flip();
      tick();
      target_table = ident_tbl();
      pulse_start();
      repeat (49) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      vectors++;
      if (busy !== 1'b0 || dut_in !== 4'h0) begin
         miscompares++;
         $display("FAIL abort_state: busy=%b din=%h want 0/0", busy, dut_in);
      end
      dn = 0;
      for (int i = 0; i < 200; i++) begin
         tick();
         if (done) dn++;
      end
      vectors++;
      if (dn != 0) begin
         miscompares++;
         $display("FAIL abort_no_done: got %0d pulses want 0", dn);
      end
      vectors++;
      if (fitness !== 7'd63 || perfect !== 1'b0) begin
         miscompares++;
         $display("FAIL abort_keep: fit=%0d perf=%b want 63/0", fitness, perfect);
      end
`ifdef TT_FAIL_CAPTURE_EN
      vectors++;
      if ({fail_valid, fail_vec, fail_mask} !== {1'b1, 4'h9, 4'b0100}) begin
         miscompares++;
         $display("FAIL abort_capture: fv=%b vec=%h mask=%b want 1/9/0100",
                  fail_valid, fail_vec, fail_mask);
      end
`endif
      abort = 1'b1;
      start = 1'b1;
      tick();
      abort = 1'b0;
      start = 1'b0;
      tick();
      vectors++;
      if (busy !== 1'b0) begin
         miscompares++;
         $display("FAIL abort_wins: busy=%b want 0", busy);
      end
   endtask

   task automatic test_rst_mid();
      int lat;
      loop = 1'b1;
      target_table = ident_tbl();
      pulse_start();
      repeat (69) tick();
      #2;
      rst = 1'b1;
      #1;
      vectors++;
      if ({busy, done, perfect, fitness, dut_in, fail_valid, fail_vec, fail_mask}
          !== '0) begin
         miscompares++;
         $display("FAIL rst_mid: busy=%b fit=%0d din=%h fv=%b want 0",
                  busy, fitness, dut_in, fail_valid);
      end
      tick();
      rst = 1'b0;
      tick();
      pulse_start();
      wait_done(lat);
      vectors++;
      if (lat != 145 || fitness !== 7'd64 || perfect !== 1'b1) begin
         miscompares++;
         $display("FAIL rst_restart: lat=%0d fit=%0d perf=%b want 145/64/1",
                  lat, fitness, perfect);
      end
   endtask

   task automatic test_back_to_back();
      int dn;
      int lat;
      loop = 1'b1;
      target_table = ident_tbl();
      pulse_start();
      target_table = '0;
      repeat (19) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (124) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      vectors++;
      if (done !== 1'b1 || fitness !== 7'd64) begin
         miscompares++;
         $display("FAIL b2b_first: done=%b fit=%0d want 1/64", done, fitness);
      end
      tick();
      vectors++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         miscompares++;
         $display("FAIL b2b_ignored: busy=%b done=%b want 0/0", busy, done);
      end
      dn = 0;
      for (int i = 0; i < 160; i++) begin
         tick();
         if (done) dn++;
      end
      vectors++;
      if (dn != 0) begin
         miscompares++;
         $display("FAIL b2b_single: extra %0d pulses want 0", dn);
      end
      target_table = ident_tbl();
      pulse_start();
      wait_done(lat);
      vectors++;
      if (lat != 145 || fitness !== 7'd64 || perfect !== 1'b1) begin
         miscompares++;
         $display("FAIL b2b_second: lat=%0d fit=%0d perf=%b want 145/64/1",
                  lat, fitness, perfect);
      end
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      test_reset();
      test_loopback();
      test_const();
      test_flip();
      test_abort();
      test_rst_mid();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
